// File: rtl/register_file_pkg.sv
// Shared types and defaults for the register_file block (optional bypass: REGFILE_BYPASS_EN).
package register_file_pkg;

    typedef enum logic [1:0] {
        WOP_LOAD  = 2'b00,
        WOP_INC   = 2'b01,
        WOP_DEC   = 2'b10,
        WOP_CLEAR = 2'b11
    } wop_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_NUM_REGS = 4;

endpackage

// File: rtl/register_file_entry.sv
// One register_file word: storage, valid bit and the next-value / wrap logic for the write port.
module reg_entry
    import register_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             we,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic [WIDTH-1:0] nxt_q,
    output logic             nxt_valid,
    output logic             wrap_nxt
);

    // Next value is computed every cycle so the top can also use it for same-cycle bypass.
    always_comb begin
        nxt_q     = q;
        nxt_valid = 1'b1;
        wrap_nxt  = 1'b0;
        case (wop_t'(op))
            WOP_LOAD:  nxt_q = d;
            WOP_INC: begin
                nxt_q    = q + WIDTH'(1);
                wrap_nxt = &q;
            end
            WOP_DEC: begin
                nxt_q    = q - WIDTH'(1);
                wrap_nxt = ~|q;
            end
            WOP_CLEAR: begin
                nxt_q     = '0;
                nxt_valid = 1'b0;
            end
            default: nxt_q = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (we) begin
            q     <= nxt_q;
            valid <= nxt_valid;
        end
    end

endmodule

// File: rtl/register_file.sv
// General-purpose register bank: one LOAD/INC/DEC/CLEAR write port, two async read ports, WRAP flag.
// Define REGFILE_BYPASS_EN to forward the in-flight write value to matching read ports.
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             CE,
    input  logic [1:0]       WOP,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    RADDR_A,
    input  logic [AW-1:0]    RADDR_B,
    output logic [WIDTH-1:0] QA,
    output logic [WIDTH-1:0] QB,
    output logic             QA_VALID,
    output logic             QB_VALID,
    output logic             WRAP
);

    logic [NUM_REGS-1:0][WIDTH-1:0] q_all;
    logic [NUM_REGS-1:0][WIDTH-1:0] nq_all;
    logic [NUM_REGS-1:0]            v_all;
    logic [NUM_REGS-1:0]            nv_all;
    logic [NUM_REGS-1:0]            wrap_all;
    logic                           wrap_q;
    wop_t                           op;

    assign op = wop_t'(WOP);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_ent
        reg_entry #(.WIDTH(WIDTH)) u_ent (
            .clk       (CLK),
            .clr_n     (CLR_N),
            .we        (CE && (WADDR == AW'(i))),
            .op        (WOP),
            .d         (D),
            .q         (q_all[i]),
            .valid     (v_all[i]),
            .nxt_q     (nq_all[i]),
            .nxt_valid (nv_all[i]),
            .wrap_nxt  (wrap_all[i])
        );
    end

    // WRAP only moves on INC/DEC; LOAD and CLEAR leave it alone.
    always_ff @(posedge CLK) begin
        if (!CLR_N)
            wrap_q <= 1'b0;
        else if (CE && (op == WOP_INC || op == WOP_DEC))
            wrap_q <= wrap_all[WADDR];
    end

    assign WRAP = wrap_q;

`ifdef REGFILE_BYPASS_EN
    logic byp_a, byp_b;

    assign byp_a    = CE && CLR_N && (RADDR_A == WADDR);
    assign byp_b    = CE && CLR_N && (RADDR_B == WADDR);
    assign QA       = byp_a ? nq_all[WADDR] : q_all[RADDR_A];
    assign QB       = byp_b ? nq_all[WADDR] : q_all[RADDR_B];
    assign QA_VALID = byp_a ? nv_all[WADDR] : v_all[RADDR_A];
    assign QB_VALID = byp_b ? nv_all[WADDR] : v_all[RADDR_B];
`else
    logic unused_bypass;

    assign QA       = q_all[RADDR_A];
    assign QB       = q_all[RADDR_B];
    assign QA_VALID = v_all[RADDR_A];
    assign QB_VALID = v_all[RADDR_B];
    assign unused_bypass = ^{nq_all, nv_all};
`endif

endmodule

// File: tb/tb_register_file.sv
// Randomized bench for register_file against an array-based reference model, plus directed literal checks.
module tb_register_file;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit x 4 instance
    logic       clr_n = 1'b0, ce = 1'b0;
    logic [1:0] wop = 2'd0, waddr = 2'd0, ra = 2'd0, rb = 2'd0;
    logic [7:0] d = 8'h00;
    logic [7:0] qa, qb;
    logic       qav, qbv, wrap;

    register_file #(.WIDTH(8), .NUM_REGS(4)) dut (
        .CLK(clk), .CLR_N(clr_n), .CE(ce), .WOP(wop), .WADDR(waddr), .D(d),
        .RADDR_A(ra), .RADDR_B(rb), .QA(qa), .QB(qb),
        .QA_VALID(qav), .QB_VALID(qbv), .WRAP(wrap)
    );

    // 16-bit x 8 instance
    logic        c_clr_n = 1'b0, c_ce = 1'b0;
    logic [1:0]  c_wop = 2'd0;
    logic [2:0]  c_waddr = 3'd0, c_ra = 3'd0, c_rb = 3'd0;
    logic [15:0] c_d = 16'h0000;
    logic [15:0] c_qa, c_qb;
    logic        c_qav, c_qbv, c_wrap;

    register_file #(.WIDTH(16), .NUM_REGS(8)) dut16 (
        .CLK(clk), .CLR_N(c_clr_n), .CE(c_ce), .WOP(c_wop), .WADDR(c_waddr), .D(c_d),
        .RADDR_A(c_ra), .RADDR_B(c_rb), .QA(c_qa), .QB(c_qb),
        .QA_VALID(c_qav), .QB_VALID(c_qbv), .WRAP(c_wrap)
    );

    int nvec = 0, nerr = 0;
    bit armed = 1'b0;

    // Reference state: plain arrays updated from the operation rules.
    logic [7:0] mem [4];
    bit         vld [4];
    bit         mwrap;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= 8'h00;
                vld[i] <= 1'b0;
            end
            mwrap <= 1'b0;
            armed <= 1'b1;
        end else if (armed && ce) begin
            case (wop)
                2'd0: begin
                    mem[waddr] <= d;
                    vld[waddr] <= 1'b1;
                end
                2'd1: begin
                    mem[waddr] <= 8'((int'(mem[waddr]) + 1) % 256);
                    vld[waddr] <= 1'b1;
                    mwrap      <= (mem[waddr] == 8'hFF);
                end
                2'd2: begin
                    mem[waddr] <= 8'((int'(mem[waddr]) + 255) % 256);
                    vld[waddr] <= 1'b1;
                    mwrap      <= (mem[waddr] == 8'h00);
                end
                default: begin
                    mem[waddr] <= 8'h00;
                    vld[waddr] <= 1'b0;
                end
            endcase
        end
    end

    // {valid, data} a read port must present for address a right now.
    function automatic logic [8:0] exp_rd(input logic [1:0] a);
        logic [8:0] r;
        r = {vld[a], mem[a]};
`ifdef REGFILE_BYPASS_EN
        if (ce && clr_n && a == waddr) begin
            case (wop)
                2'd0:    r = {1'b1, d};
                2'd1:    r = {1'b1, 8'((int'(mem[a]) + 1) % 256)};
                2'd2:    r = {1'b1, 8'((int'(mem[a]) + 255) % 256)};
                default: r = 9'h000;
            endcase
        end
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            logic [8:0] ea, eb;
            ea = exp_rd(ra);
            eb = exp_rd(rb);
            chk("qa",     32'(qa),   32'(ea[7:0]));
            chk("qb",     32'(qb),   32'(eb[7:0]));
            chk("qa_vld", 32'(qav),  32'(ea[8]));
            chk("qb_vld", 32'(qbv),  32'(eb[8]));
            chk("wrap",   32'(wrap), 32'(mwrap));
        end
    end

    task automatic drive(input logic rn, input logic c, input logic [1:0] op, input int wa,
                         input logic [7:0] dd, input int a, input int b);
        @(posedge clk);
        #1;
        clr_n = rn; ce = c; wop = op; waddr = wa[1:0]; d = dd; ra = a[1:0]; rb = b[1:0];
    endtask

    // Idle cycle with new read addresses, then literal checks on the settled outputs.
    task automatic look(input int a, input int b, input logic [7:0] eqa, input logic [7:0] eqb,
                        input logic eva, input logic evb, input logic ew);
        drive(1'b1, 1'b0, 2'd0, 0, 8'h00, a, b);
        #2;
        chk("lit_qa", 32'(qa), 32'(eqa));
        chk("lit_qb", 32'(qb), 32'(eqb));
        chk("lit_qa_vld", 32'(qav), 32'(eva));
        chk("lit_qb_vld", 32'(qbv), 32'(evb));
        chk("lit_wrap", 32'(wrap), 32'(ew));
    endtask

    task automatic drive16(input logic rn, input logic c, input logic [1:0] op, input int wa,
                           input logic [15:0] dd, input int a);
        @(posedge clk);
        #1;
        c_clr_n = rn; c_ce = c; c_wop = op; c_waddr = wa[2:0]; c_d = dd; c_ra = a[2:0]; c_rb = 3'd0;
    endtask

    initial begin
        // Reset with a LOAD pending: it must be discarded.
        drive(1'b0, 1'b1, 2'd0, 0, 8'h77, 0, 0);
        drive(1'b0, 1'b1, 2'd0, 1, 8'h77, 0, 1);
        look(0, 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        look(2, 3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 1'b1, 2'd0, 2, 8'hA5, 0, 0);
        drive(1'b1, 1'b1, 2'd0, 1, 8'h3C, 0, 0);
        look(2, 1, 8'hA5, 8'h3C, 1'b1, 1'b1, 1'b0);
        look(0, 3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 1'b1, 2'd0, 3, 8'hFF, 0, 0);
        drive(1'b1, 1'b1, 2'd1, 3, 8'h00, 0, 0);
        look(3, 3, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 2'd1, 3, 8'h00, 0, 0);
        look(3, 2, 8'h01, 8'hA5, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 2'd2, 0, 8'h00, 0, 0);
        look(0, 3, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b1);

        drive(1'b1, 1'b0, 2'd0, 1, 8'h10, 0, 0);
        look(1, 1, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 2'd3, 2, 8'h00, 0, 0);
        look(2, 1, 8'h00, 8'h3C, 1'b0, 1'b1, 1'b1);

        drive(1'b1, 1'b1, 2'd0, 0, 8'h55, 0, 1);
        #2;
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle_qa", 32'(qa), 32'h55);
`else
        chk("same_cycle_qa", 32'(qa), 32'hFF);
`endif
        look(0, 0, 8'h55, 8'h55, 1'b1, 1'b1, 1'b1);

        for (int n = 0; n < 1500; n++) begin
            logic [7:0] dv;
            case ($urandom_range(0, 3))
                0:       dv = 8'h00;
                1:       dv = 8'hFF;
                default: dv = 8'($urandom);
            endcase
            drive($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0, 2'($urandom),
                  int'($urandom_range(0, 3)), dv,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        drive(1'b1, 1'b0, 2'd0, 0, 8'h00, 0, 0);

        // 16-bit x 8: top-entry wrap must not disturb the others.
        drive16(1'b0, 1'b0, 2'd0, 0, 16'h0000, 0);
        drive16(1'b1, 1'b0, 2'd0, 0, 16'h0000, 0);
        for (int i = 0; i < 7; i++) drive16(1'b1, 1'b1, 2'd0, i, 16'(16'h1000 + i * 16'h0101), 0);
        drive16(1'b1, 1'b1, 2'd0, 7, 16'hFFFF, 0);
        drive16(1'b1, 1'b1, 2'd1, 7, 16'h0000, 0);
        drive16(1'b1, 1'b0, 2'd0, 0, 16'h0000, 7);
        #2;
        chk("w16_r7", 32'(c_qa), 32'h0000);
        chk("w16_r7_vld", 32'(c_qav), 32'h1);
        chk("w16_wrap", 32'(c_wrap), 32'h1);
        for (int i = 0; i < 7; i++) begin
            drive16(1'b1, 1'b0, 2'd0, 0, 16'h0000, i);
            #2;
            chk("w16_rN", 32'(c_qa), 32'(16'h1000 + i * 16'h0101));
            chk("w16_rN_vld", 32'(c_qav), 32'h1);
        end

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
